// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants for the Sudoku display raster path: 640x480@60 timing
// (pixel clock derived from a 100 MHz board clock), the counter width used by
// the timing generator, and the 12-bit RGB colours used by the colour stage.
// A small range helper keeps the visible-window decode readable.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_CLK_DIV     = 4;
    localparam int unsigned VGA_H_TOTAL     = 800;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_ACT_START = 144;
    localparam int unsigned VGA_H_ACT_END   = 784;
    localparam int unsigned VGA_V_TOTAL     = 525;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_ACT_START = 35;
    localparam int unsigned VGA_V_ACT_END   = 515;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] GREEN = 12'h0F0;
    localparam logic [11:0] BLUE  = 12'h00F;

    // True when lo <= val < hi (half-open window).
    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_en.sv
// pix_en_gen
// Clock divider producing a one-clk pixel enable every CLK_DIV board clocks.
// The divider counts 0..CLK_DIV-1; pix_en is registered and is high for the
// clk cycle after the divider sat at CLK_DIV-1, so the first pulse appears on
// the CLK_DIV-th edge after reset release.
// Ports:
//   clk     in  board clock
//   reset_n in  asynchronous active-low reset
//   pix_en  out one-clk pulse per pixel period
module pix_en_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic pix_en
);

    localparam int unsigned         DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             pix_en_r;

    // Divider counter and registered pixel enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r    <= '0;
            pix_en_r <= 1'b0;
        end else begin
            pix_en_r <= (div_r == DIV_LAST);
            if (div_r == DIV_LAST) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    assign pix_en = pix_en_r;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing for the Sudoku display: divides clk down to a pixel enable,
// runs horizontal/vertical counters and drives the VGA sync pins. hSync,
// vSync and bright are decoded from the next-state counters and registered,
// so they change on the same edge as hCount/vCount with no skew or glitch.
// Optional build macro VGA_FRAME_CNT_EN adds a 16-bit frame counter output
// (cursor blink timebase) that increments on every frame_start.
// Ports:
//   clk         in  board clock (100 MHz)
//   reset_n     in  asynchronous active-low reset
//   hCount      out pixel column, 0..H_TOTAL-1
//   vCount      out line, 0..V_TOTAL-1
//   hSync       out horizontal sync, active low
//   vSync       out vertical sync, active low
//   bright      out high inside the visible window
//   pix_en      out one-clk pulse per pixel period
//   frame_start out one-clk pulse when the raster wraps to (0,0)
//   frame_cnt   out frames since reset, wrapping (VGA_FRAME_CNT_EN only)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
    parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_ACT_START = VGA_H_ACT_START,
    parameter int unsigned H_ACT_END   = VGA_H_ACT_END,
    parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_ACT_START = VGA_V_ACT_START,
    parameter int unsigned V_ACT_END   = VGA_V_ACT_END
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic             pix_en,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT0_C  = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] H_ACT1_C  = CNT_W'(H_ACT_END);
    localparam logic [CNT_W-1:0] V_ACT0_C  = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] V_ACT1_C  = CNT_W'(V_ACT_END);

    logic             pix_en_s;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             wrap_s;
    logic             hsync_next_s;
    logic             vsync_next_s;
    logic             bright_next_s;

    logic [CNT_W-1:0] hcount_r;
    logic [CNT_W-1:0] vcount_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             bright_r;
    logic             frame_start_r;

    pix_en_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .pix_en  (pix_en_s)
    );

    // Next-state raster position; counters only move on a pixel enable.
    always_comb begin
        h_next_s = hcount_r;
        v_next_s = vcount_r;
        wrap_s   = 1'b0;
        if (pix_en_s) begin
            if (hcount_r == H_LAST_C) begin
                h_next_s = '0;
                if (vcount_r == V_LAST_C) begin
                    v_next_s = '0;
                    wrap_s   = 1'b1;
                end else begin
                    v_next_s = vcount_r + CNT_W'(1);
                end
            end else begin
                h_next_s = hcount_r + CNT_W'(1);
            end
        end else begin
            h_next_s = hcount_r;
        end
    end

    // Sync and visible-window decode from the next-state position.
    always_comb begin
        hsync_next_s  = ~(h_next_s < H_SYNC_C);
        vsync_next_s  = ~(v_next_s < V_SYNC_C);
        bright_next_s = in_window(h_next_s, H_ACT0_C, H_ACT1_C) &&
                        in_window(v_next_s, V_ACT0_C, V_ACT1_C);
    end

    // Raster state and registered decode outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_r      <= '0;
            vcount_r      <= '0;
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            bright_r      <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hcount_r      <= h_next_s;
            vcount_r      <= v_next_s;
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            bright_r      <= bright_next_s;
            frame_start_r <= wrap_s;
        end
    end

    assign hCount      = hcount_r;
    assign vCount      = vcount_r;
    assign hSync       = hsync_r;
    assign vSync       = vsync_r;
    assign bright      = bright_r;
    assign pix_en      = pix_en_s;
    assign frame_start = frame_start_r;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_r <= 16'd0;
        end else if (wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Two instances share clock and reset:
// one with the real 640x480 geometry (reset, line wrap, hSync edge) and one
// with a shrunken geometry so whole frames fit in a short run (visible window
// edges, frame wrap, vSync). Expected outputs come from an arithmetic model
// driven only by the number of clk edges since reset release.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int SD = 4, SH = 20, SHS = 3, SHA0 = 5, SHA1 = 17;
    localparam int SV = 10, SVS = 2, SVA0 = 3, SVA1 = 8;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        br;
        logic        pe;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic checking = 1'b0;
    int   n = 0;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] fc_base = 16'd0;
    int          fc_ref = 0;

    logic [9:0] hc0, vc0, hc1, vc1;
    logic hs0, vs0, br0, pe0, fs0, hs1, vs1, br1, pe1, fs1;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
`endif

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .reset_n(rst_n), .hCount(hc0), .vCount(vc0), .hSync(hs0),
        .vSync(vs0), .bright(br0), .pix_en(pe0), .frame_start(fs0)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(SD), .H_TOTAL(SH), .H_SYNC(SHS), .H_ACT_START(SHA0),
        .H_ACT_END(SHA1), .V_TOTAL(SV), .V_SYNC(SVS), .V_ACT_START(SVA0),
        .V_ACT_END(SVA1)
    ) dut_s (
        .clk(clk), .reset_n(rst_n), .hCount(hc1), .vCount(vc1), .hSync(hs1),
        .vSync(vs1), .bright(br1), .pix_en(pe1), .frame_start(fs1)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    // Edges since reset release; cleared the moment reset is asserted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // Expected outputs after n clk edges since reset release.
    function automatic exp_t model(input int nn, input int d, input int h, input int v,
                                   input int hsy, input int vsy, input int ha0,
                                   input int ha1, input int va0, input int va1);
        exp_t e;
        int a, p, hh, vv;
        a  = (nn >= d + 1) ? (nn - 1) / d : 0;   // pixel advances so far
        p  = a % (h * v);
        hh = p % h;
        vv = p / h;
        e.h  = 10'(hh);
        e.v  = 10'(vv);
        e.hs = (hh >= hsy);
        e.vs = (vv >= vsy);
        e.br = (hh >= ha0) && (hh < ha1) && (vv >= va0) && (vv < va1);
        e.pe = (nn >= d) && (nn % d == 0);
        e.fs = (nn >= d + 1) && ((nn - 1) % d == 0) && (p == 0);
        e.fc = 16'(a / (h * v));
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    exp_t e0, e1, a0, a1;

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            e0 = model(n, VGA_CLK_DIV, VGA_H_TOTAL, VGA_V_TOTAL, VGA_H_SYNC, VGA_V_SYNC,
                       VGA_H_ACT_START, VGA_H_ACT_END, VGA_V_ACT_START, VGA_V_ACT_END);
            e1 = model(n, SD, SH, SV, SHS, SVS, SHA0, SHA1, SVA0, SVA1);
            e1.fc = fc_base + 16'(int'(e1.fc) - fc_ref);
            a0 = {hc0, vc0, hs0, vs0, br0, pe0, fs0, 16'd0};
            a1 = {hc1, vc1, hs1, vs1, br1, pe1, fs1, 16'd0};
`ifdef VGA_FRAME_CNT_EN
            a0.fc = fc0;
            a1.fc = fc1;
`else
            e0.fc = 16'd0;
            e1.fc = 16'd0;
`endif
            chk("model_full", 64'(a0), 64'(e0));
            chk("model_small", 64'(a1), 64'(e1));
            // Hand-computed anchors for the full geometry.
            if (n == 3)    chk("first_pix_en_not_yet", 64'(pe0), 64'd0);
            if (n == 4)    chk("first_pix_en", 64'({pe0, hc0}), 64'({1'b1, 10'd0}));
            if (n == 5)    chk("hcount_first_step", 64'({pe0, hc0}), 64'({1'b0, 10'd1}));
            if (n == 381)  chk("hsync_low_at_95", 64'({hc0, hs0}), 64'({10'd95, 1'b0}));
            if (n == 385)  chk("hsync_high_at_96", 64'({hc0, hs0}), 64'({10'd96, 1'b1}));
            if (n == 3197) chk("line_end", 64'({hc0, vc0}), 64'({10'd799, 10'd0}));
            if (n == 3201) chk("line_wrap", 64'({hc0, vc0, vs0, fs0}), 64'({10'd0, 10'd1, 1'b0, 1'b0}));
            if (n == 6401) chk("vsync_high_line2", 64'({vc0, vs0}), 64'({10'd2, 1'b1}));
            // Hand-computed anchors for the small geometry.
            if (n == 181)  chk("bright_5_2", 64'(br1), 64'd0);
            if (n == 257)  chk("bright_4_3", 64'(br1), 64'd0);
            if (n == 261)  chk("bright_5_3", 64'(br1), 64'd1);
            if (n == 625)  chk("bright_16_7", 64'(br1), 64'd1);
            if (n == 629)  chk("bright_17_7", 64'(br1), 64'd0);
            if (n == 157)  chk("vsync_low_line1", 64'(vs1), 64'd0);
            if (n == 161)  chk("vsync_high_line2s", 64'(vs1), 64'd1);
            if (n == 797)  chk("frame_end", 64'({hc1, vc1, fs1}), 64'({10'd19, 10'd9, 1'b0}));
            if (n == 801)  chk("frame_wrap", 64'({hc1, vc1, fs1}), 64'({10'd0, 10'd0, 1'b1}));
            if (n == 802)  chk("frame_start_one_clk", 64'(fs1), 64'd0);
        end
    end

    initial begin
        int run1, hold, dly;
        #1 rst_n = 1'b0;
        checking = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run1 = 6500 + int'($urandom_range(0, 600));
        repeat (3000) @(posedge clk);
`ifdef VGA_FRAME_CNT_EN
        @(negedge clk);
        force dut_s.frame_cnt_r = 16'hFFFF;
        #1 release dut_s.frame_cnt_r;
        fc_base = 16'hFFFF;
        fc_ref  = ((n - 1) / SD) / (SH * SV);
`endif
        repeat (run1 - 3000) @(posedge clk);

        // Asynchronous reset between clk edges, mid-frame.
        @(negedge clk);
        dly = int'($urandom_range(1, 3));
        #(dly) rst_n = 1'b0;
        #1;
        chk("async_reset_full", 64'({hc0, vc0, hs0, vs0, br0, pe0, fs0}), 64'd0);
        chk("async_reset_small", 64'({hc1, vc1, hs1, vs1, br1, pe1, fs1}), 64'd0);
        fc_base = 16'd0;
        fc_ref  = 0;
        hold = int'($urandom_range(3, 12));
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (900 + int'($urandom_range(0, 200))) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
